// File: rtl/ball_motion.sv
// ---------------------------------------------------------------------------
// ball_motion
//   Per-frame ball physics engine. Keeps position and direction for CNT ball
//   slots. Each frame_tick walks the slots one per cycle, moving live balls by
//   SPEED px per axis, bouncing them off the left/right/top walls and the
//   paddle, and dropping balls that reach the bottom of the playfield.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   frame_tick   1-cycle pulse, starts one physics update (ignored when busy)
//   launch       1-cycle pulse, spawns a ball above the paddle at launch_x
//   launch_x     spawn x
//   paddle_x     left edge of the paddle
//   radius       ball radius in px
//   xs, ys       packed ball positions; ball i is xs[i*10+:10] / ys[i*10+:10]
//   active       per-slot live flags
//   busy         update in progress (high for exactly CNT cycles)
//   lost         1-cycle pulse when a ball drops out of the bottom
//   all_lost     no ball is live
// ---------------------------------------------------------------------------
module ball_motion #(
    parameter int CNT      = 3,
    parameter int H_MAX    = 640,
    parameter int V_MAX    = 480,
    parameter int SPEED    = 2,
    parameter int PADDLE_Y = 440,
    parameter int PADDLE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              launch,
    input  logic [9:0]        launch_x,
    input  logic [9:0]        paddle_x,
    input  logic [5:0]        radius,
    output logic [CNT*10-1:0] xs,
    output logic [CNT*10-1:0] ys,
    output logic [CNT-1:0]    active,
    output logic              busy,
    output logic              lost,
    output logic              all_lost
);
    localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;

    // All physics arithmetic is 11 bits wide so x+SPEED+radius cannot wrap.
    localparam logic [10:0] SPD   = 11'(SPEED);
    localparam logic [10:0] H_LIM = 11'(H_MAX);
    localparam logic [10:0] V_LIM = 11'(V_MAX);
    localparam logic [10:0] PY    = 11'(PADDLE_Y);
    localparam logic [10:0] PW    = 11'(PADDLE_W);

    typedef enum logic {IDLE, UPDATE} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CNT-1:0][9:0] x_q, x_d, y_q, y_d;
    logic [CNT-1:0]      dx_q, dx_d, dy_q, dy_d, act_q, act_d;
    logic                pend_q, pend_d;
    logic                lost_q, lost_d;

    // Operands of the slot being processed this cycle.
    logic [9:0] cur_x, cur_y;
    logic       cur_dx, cur_dy;

    // NOTE: every signal driven from always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cur_x  = '0;
        cur_y  = '0;
        cur_dx = 1'b0;
        cur_dy = 1'b0;
        for (int i = 0; i < CNT; i++) begin
            if (idx_q == IW'(i)) begin
                cur_x  = x_q[i];
                cur_y  = y_q[i];
                cur_dx = dx_q[i];
                cur_dy = dy_q[i];
            end
        end
    end

    logic [10:0] x11, y11, r11, px11;
    assign x11  = {1'b0, cur_x};
    assign y11  = {1'b0, cur_y};
    assign r11  = {5'd0, radius};
    assign px11 = {1'b0, paddle_x};

    // Horizontal rule.
    logic [9:0] nx;
    logic       ndx;
    always_comb begin
        nx  = cur_x;
        ndx = cur_dx;
        if (cur_dx) begin
            if (x11 + SPD + r11 >= H_LIM) begin
                nx  = 10'(H_LIM - 11'd1 - r11);
                ndx = 1'b0;
            end else begin
                nx = 10'(x11 + SPD);
            end
        end else begin
            if (x11 < r11 + SPD) begin
                nx  = 10'(r11);
                ndx = 1'b1;
            end else begin
                nx = 10'(x11 - SPD);
            end
        end
    end

    // Vertical rule. The paddle is only checked on the frame that carries the
    // ball across its top surface; once past that plane the ball falls through.
    logic       paddle_hit;
    logic [9:0] ny;
    logic       ndy, drop;
    assign paddle_hit = (y11 + r11 < PY) && (y11 + SPD + r11 >= PY) &&
                        (x11 >= px11) && (x11 <= px11 + PW - 11'd1);

    always_comb begin
        ny   = cur_y;
        ndy  = cur_dy;
        drop = 1'b0;
        if (!cur_dy) begin
            if (y11 < r11 + SPD) begin
                ny  = 10'(r11);
                ndy = 1'b1;
            end else begin
                ny = 10'(y11 - SPD);
            end
        end else if (paddle_hit) begin
            ny  = 10'(PY - r11 - 11'd1);
            ndy = 1'b0;
        end else if (y11 + SPD + r11 >= V_LIM) begin
            drop = 1'b1;
        end else begin
            ny = 10'(y11 + SPD);
        end
    end

    // Lowest-index free slot; scanning downwards lets the lowest index win.
    logic          free_ok;
    logic [IW-1:0] free_idx;
    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        for (int i = CNT - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_ok  = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        act_d   = act_q;
        pend_d  = pend_q;
        lost_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                    if (launch) pend_d = 1'b1;
                end else if (launch || pend_q) begin
                    // One spawn per cycle; a fresh launch alongside a pending
                    // one stays pending. Spawns into a full table are dropped.
                    pend_d = pend_q && launch;
                    for (int i = 0; i < CNT; i++) begin
                        if (free_ok && free_idx == IW'(i)) begin
                            x_d[i]   = launch_x;
                            y_d[i]   = 10'(PY - r11 - 11'd1);
                            dx_d[i]  = 1'b1;
                            dy_d[i]  = 1'b0;
                            act_d[i] = 1'b1;
                        end
                    end
                end
            end
            UPDATE: begin
                if (launch) pend_d = 1'b1;
                for (int i = 0; i < CNT; i++) begin
                    if (idx_q == IW'(i) && act_q[i]) begin
                        if (drop) begin
                            act_d[i] = 1'b0;
                            lost_d   = 1'b1;
                        end else begin
                            x_d[i]  = nx;
                            y_d[i]  = ny;
                            dx_d[i] = ndx;
                            dy_d[i] = ndy;
                        end
                    end
                end
                if (idx_q == IW'(CNT - 1)) state_d = IDLE;
                else                       idx_d   = idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the ball table is real state visible on the outputs, so it
            // is cleared by reset rather than left to power-up contents.
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            act_q   <= '0;
            pend_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
        end
    end

    assign xs       = x_q;
    assign ys       = y_q;
    assign active   = act_q;
    assign busy     = (state_q == UPDATE);
    assign lost     = lost_q;
    assign all_lost = ~|act_q;

endmodule

// File: tb/tb_ball_motion.sv
// ---------------------------------------------------------------------------
// tb_ball_motion
//   Scoreboard bench for ball_motion (default parameters, radius=4 unless a
//   step says otherwise). Stimulus pushes the expected ball table for every
//   output event it causes (end of an update, or a spawn); a monitor pops and
//   compares when the DUT presents that event.
// ---------------------------------------------------------------------------
module tb_ball_motion;
    logic        clk = 1'b0;
    logic        rst, frame_tick, launch;
    logic [9:0]  launch_x, paddle_x;
    logic [5:0]  radius;
    logic [29:0] xs, ys;
    logic [2:0]  active;
    logic        busy, lost, all_lost;

    ball_motion dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .launch    (launch),
        .launch_x  (launch_x),
        .paddle_x  (paddle_x),
        .radius    (radius),
        .xs        (xs),
        .ys        (ys),
        .active    (active),
        .busy      (busy),
        .lost      (lost),
        .all_lost  (all_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        string       name;
        logic [29:0] ex;
        logic [29:0] ey;
        logic [2:0]  ea;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lost_cycles = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, got, got, want, want);
        end
    endtask

    function automatic logic [29:0] p3(int s0, int s1, int s2);
        return {10'(s2), 10'(s1), 10'(s0)};
    endfunction

    task automatic push(bit chk, string name, logic [29:0] ex, logic [29:0] ey, logic [2:0] ea);
        exp_t e;
        e.chk  = chk;
        e.name = name;
        e.ex   = ex;
        e.ey   = ey;
        e.ea   = ea;
        sb_q.push_back(e);
    endtask

    // Monitor: an output event is the fall of busy or a newly set active bit.
    initial begin : monitor
        logic       busy_p;
        logic [2:0] act_p;
        exp_t       e;
        busy_p = 1'bx;
        act_p  = 'x;
        forever begin
            @(negedge clk);
            if (lost === 1'b1) lost_cycles++;
            if ((busy_p === 1'b1 && busy === 1'b0) ||
                (!$isunknown(act_p) && !$isunknown(active) && (active & ~act_p) != 3'b000)) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_event", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk) begin
                        check({e.name, "_xs"}, 32'(xs), 32'(e.ex));
                        check({e.name, "_ys"}, 32'(ys), 32'(e.ey));
                        check({e.name, "_active"}, 32'(active), 32'(e.ea));
                    end
                end
            end
            busy_p = busy;
            act_p  = active;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_launch(logic [9:0] x);
        @(negedge clk);
        launch   = 1'b1;
        launch_x = x;
        @(negedge clk);
        launch   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame: push expectation, pulse frame_tick, wait (bounded) for busy
    // to fall. Returns at the negedge where busy is first seen low.
    task automatic frame(bit chk, string name, logic [29:0] ex, logic [29:0] ey,
                         logic [2:0] ea, bit chk_busy);
        int n;
        n = 0;
        push(chk, name, ex, ey, ea);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (chk_busy || n >= 20) check({name, "_busy_cycles"}, 32'(n), 32'd3);
    endtask

    task automatic walk(int k);
        for (int i = 0; i < k; i++) frame(1'b0, "walk", '0, '0, '0, 1'b0);
    endtask

    initial begin : stim
        int n;
        int lost_before;
        rst        = 1'b1;
        frame_tick = 1'b0;
        launch     = 1'b0;
        launch_x   = '0;
        paddle_x   = 10'd1000;
        radius     = 6'd4;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_active", 32'(active), 32'd0);
        check("rst_xs", 32'(xs), 32'd0);
        check("rst_ys", 32'(ys), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_all_lost", 32'(all_lost), 32'd1);
        rst = 1'b0;

        // Spawns and a basic frame
        push(1'b1, "spawn0", p3(100, 0, 0), p3(435, 0, 0), 3'b001);
        do_launch(10'd100);
        push(1'b1, "spawn1", p3(100, 200, 0), p3(435, 435, 0), 3'b011);
        do_launch(10'd200);
        check("all_lost_live", 32'(all_lost), 32'd0);
        frame(1'b1, "frame1", p3(102, 202, 0), p3(433, 433, 0), 3'b011, 1'b1);

        // frame_tick held into the busy window must not restart the update
        push(1'b1, "frame_ignore", p3(104, 204, 0), p3(431, 431, 0), 3'b011);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        check("busy_after_tick", 32'(busy), 32'd1);
        @(negedge clk);
        frame_tick = 1'b0;
        n = 1;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("ignore_busy_cycles", 32'(n), 32'd3);
        repeat (2) @(negedge clk);
        check("ignore_stays_idle", 32'(busy), 32'd0);

        // Fill the table, then a launch into a full table is dropped
        push(1'b1, "spawn2", p3(104, 204, 400), p3(431, 431, 435), 3'b111);
        do_launch(10'd400);
        do_launch(10'd500);
        repeat (2) @(negedge clk);
        check("full_drop_active", 32'(active), 32'd7);
        check("full_drop_xs", 32'(xs), 32'(p3(104, 204, 400)));

        do_reset();
        check("reset2_all_lost", 32'(all_lost), 32'd1);

        // Right wall, then radius=63 to reach top wall, left wall and bottom
        push(1'b1, "spawn_rw", p3(634, 0, 0), p3(435, 0, 0), 3'b001);
        do_launch(10'd634);
        frame(1'b1, "right_wall", p3(635, 0, 0), p3(433, 0, 0), 3'b001, 1'b0);
        radius = 6'd63;
        frame(1'b1, "right_wall_next", p3(633, 0, 0), p3(431, 0, 0), 3'b001, 1'b0);
        walk(184);
        frame(1'b1, "top_wall", p3(263, 0, 0), p3(63, 0, 0), 3'b001, 1'b0);
        walk(100);
        frame(1'b1, "left_wall", p3(63, 0, 0), p3(265, 0, 0), 3'b001, 1'b0);
        frame(1'b1, "left_wall_next", p3(65, 0, 0), p3(267, 0, 0), 3'b001, 1'b0);
        walk(74);
        check("no_early_lost", 32'(lost_cycles), 32'd0);
        frame(1'b1, "bottom_lost", p3(213, 0, 0), p3(415, 0, 0), 3'b000, 1'b0);
        check("lost_pulse_once", 32'(lost_cycles), 32'd1);
        check("all_lost_after", 32'(all_lost), 32'd1);
        frame(1'b1, "empty_frame_hold", p3(213, 0, 0), p3(415, 0, 0), 3'b000, 1'b0);

        // Paddle hit at the right edge of the paddle (x=309, paddle 246..309)
        do_reset();
        radius   = 6'd4;
        paddle_x = 10'd246;
        push(1'b1, "spawn_ph", p3(100, 0, 0), p3(435, 0, 0), 3'b001);
        do_launch(10'd100);
        walk(215);
        frame(1'b1, "top_wall_r4", p3(532, 0, 0), p3(4, 0, 0), 3'b001, 1'b0);
        walk(51);
        frame(1'b1, "right_wall_r4", p3(635, 0, 0), p3(108, 0, 0), 3'b001, 1'b0);
        walk(163);
        frame(1'b1, "paddle_hit", p3(307, 0, 0), p3(435, 0, 0), 3'b001, 1'b0);
        frame(1'b1, "paddle_rebound", p3(305, 0, 0), p3(433, 0, 0), 3'b001, 1'b0);

        // Paddle miss just past its left edge (x=309, paddle 310..373)
        do_reset();
        paddle_x = 10'd310;
        push(1'b1, "spawn_pm", p3(100, 0, 0), p3(435, 0, 0), 3'b001);
        do_launch(10'd100);
        walk(431);
        frame(1'b1, "paddle_miss", p3(307, 0, 0), p3(436, 0, 0), 3'b001, 1'b0);
        walk(18);
        frame(1'b1, "fall_474", p3(269, 0, 0), p3(474, 0, 0), 3'b001, 1'b0);
        lost_before = lost_cycles;
        frame(1'b1, "fall_lost", p3(269, 0, 0), p3(474, 0, 0), 3'b000, 1'b0);
        check("fall_lost_pulse", 32'(lost_cycles - lost_before), 32'd1);

        // Launch in the same cycle as frame_tick is deferred until busy falls
        do_reset();
        paddle_x = 10'd1000;
        push(1'b1, "spawn_e", p3(100, 0, 0), p3(435, 0, 0), 3'b001);
        do_launch(10'd100);
        push(1'b1, "pend_frame", p3(102, 0, 0), p3(433, 0, 0), 3'b001);
        push(1'b1, "pend_spawn", p3(102, 300, 0), p3(433, 435, 0), 3'b011);
        @(negedge clk);
        frame_tick = 1'b1;
        launch     = 1'b1;
        launch_x   = 10'd300;
        @(negedge clk);
        frame_tick = 1'b0;
        launch     = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("pend_busy_cycles", 32'(n), 32'd3);
        check("pend_not_before_idle", 32'(active), 32'd1);
        @(negedge clk);
        check("pend_one_cycle_after", 32'(active), 32'd3);

        // Reset in the middle of an update aborts it and clears a pending launch
        push(1'b1, "rst_abort", '0, '0, 3'b000);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        launch     = 1'b1;
        @(negedge clk);
        launch     = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_active", 32'(active), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        check("abort_no_pending_spawn", 32'(active), 32'd0);

        repeat (2) @(negedge clk);
        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
